id_issue_stage: RTL and testbench

Parametrised decode-issue stage: takes decoded instruction fields and register-file read data, resolves operands by forwarding from later stages, and detects load-use and long-latency (multi-cycle) hazards. It registers the issued instruction into the ID/EX pipeline register with bubble, flush and hold control. It sits between the IF/ID register and the execute stage. It is the generalised successor of the fixed-width decode stage, adding:
- configurable widths,
- an internal long-op scoreboard,
- operand-use qualification,
- two-level forwarding.

---
 rtl/id_issue_stage.sv | 156 +++++++++++++++
 tb/tb_id_issue_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue_stage.sv
// rtl/id_issue_stage.sv - decode/issue stage: operand forwarding, hazard stall, long-op scoreboard, ID/EX register
// Optional WB bypass of register-file read data: define ID_WB_BYPASS_EN.
module id_issue_stage #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int CTRL_W   = 16,
    parameter int LONG_LAT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic              flush,
    input  logic              valid_in,
    input  logic [ADDR_W-1:0] rs,
    input  logic [ADDR_W-1:0] rt,
    input  logic              uses_rs,
    input  logic              uses_rt,
    input  logic [ADDR_W-1:0] rd,
    input  logic              reg_write,
    input  logic              is_load,
    input  logic              long_op,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [DATA_W-1:0] pc_plus4,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    input  logic              fwd_mem_valid,
    input  logic [ADDR_W-1:0] fwd_mem_rd,
    input  logic [DATA_W-1:0] fwd_mem_data,
    input  logic              fwd_wb_valid,
    input  logic [ADDR_W-1:0] fwd_wb_rd,
    input  logic [DATA_W-1:0] fwd_wb_data,
    output logic              stall,
    output logic              long_busy,
    output logic              ex_valid,
    output logic              ex_reg_write,
    output logic              ex_is_load,
    output logic [ADDR_W-1:0] ex_rs,
    output logic [ADDR_W-1:0] ex_rt,
    output logic [ADDR_W-1:0] ex_rd,
    output logic [DATA_W-1:0] ex_rs_data,
    output logic [DATA_W-1:0] ex_rt_data,
    output logic [DATA_W-1:0] ex_pc_plus4,
    output logic [DATA_W-1:0] ex_imm,
    output logic [CTRL_W-1:0] ex_ctrl
);

    localparam int CNT_W = $clog2(LONG_LAT + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LONG_LAT);

    logic [CNT_W-1:0]  long_cnt;
    logic [ADDR_W-1:0] long_rd;
    logic [DATA_W-1:0] rs_sel;
    logic [DATA_W-1:0] rt_sel;
    logic              load_use_haz;
    logic              long_haz;
    logic              struct_haz;
    logic              issue;

    // EX/MEM forwarding always beats the WB bypass, which sees only the older result.
    function automatic logic [DATA_W-1:0] sel_operand(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] rf_data
    );
        if (idx == '0)
            return '0;
        if (fwd_mem_valid && (fwd_mem_rd == idx))
            return fwd_mem_data;
`ifdef ID_WB_BYPASS_EN
        if (fwd_wb_valid && (fwd_wb_rd != '0) && (fwd_wb_rd == idx))
            return fwd_wb_data;
`endif
        return rf_data;
    endfunction

`ifndef ID_WB_BYPASS_EN
    logic wb_unused;
    assign wb_unused = ^{fwd_wb_valid, fwd_wb_rd, fwd_wb_data};
`endif

    always_comb begin
        rs_sel = sel_operand(rs, rf_rs_data);
        rt_sel = sel_operand(rt, rf_rt_data);
    end

    assign long_busy = (long_cnt != '0);

    always_comb begin
        load_use_haz = ex_valid && ex_is_load && ex_reg_write && (ex_rd != '0) &&
                       ((uses_rs && (rs == ex_rd)) || (uses_rt && (rt == ex_rd)));
        long_haz     = long_busy && (long_rd != '0) &&
                       ((uses_rs && (rs == long_rd)) || (uses_rt && (rt == long_rd)));
        struct_haz   = long_busy && long_op;
        stall        = valid_in && !flush && (load_use_haz || long_haz || struct_haz);
        issue        = valid_in && !stall && !flush && !hold;
    end

    // Anything that is not a clean issue (flush, stall, empty ID) becomes a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid     <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_rs        <= '0;
            ex_rt        <= '0;
            ex_rd        <= '0;
            ex_rs_data   <= '0;
            ex_rt_data   <= '0;
            ex_pc_plus4  <= '0;
            ex_imm       <= '0;
            ex_ctrl      <= '0;
        end else if (!hold) begin
            if (issue) begin
                ex_valid     <= 1'b1;
                ex_reg_write <= reg_write;
                ex_is_load   <= is_load;
                ex_rs        <= rs;
                ex_rt        <= rt;
                ex_rd        <= rd;
                ex_rs_data   <= rs_sel;
                ex_rt_data   <= rt_sel;
                ex_pc_plus4  <= pc_plus4;
                ex_imm       <= imm;
                ex_ctrl      <= ctrl_in;
            end else begin
                ex_valid     <= 1'b0;
                ex_reg_write <= 1'b0;
                ex_is_load   <= 1'b0;
                ex_rs        <= '0;
                ex_rt        <= '0;
                ex_rd        <= '0;
                ex_rs_data   <= '0;
                ex_rt_data   <= '0;
                ex_pc_plus4  <= '0;
                ex_imm       <= '0;
                ex_ctrl      <= '0;
            end
        end
    end

    // A new long op can only issue once the counter is idle, so load and decrement never collide.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            long_cnt <= '0;
            long_rd  <= '0;
        end else if (!hold) begin
            if (issue && long_op && reg_write) begin
                long_cnt <= CNT_LOAD;
                long_rd  <= rd;
            end else if (long_cnt != '0) begin
                long_cnt <= long_cnt - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_id_issue_stage.sv
// tb/tb_id_issue_stage.sv - self-checking bench for id_issue_stage with an issue scoreboard
module tb_id_issue_stage;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int CTRL_W   = 16;
    localparam int LONG_LAT = 4;

    logic              clk;
    logic              reset;
    logic              hold;
    logic              flush;
    logic              valid_in;
    logic [ADDR_W-1:0] rs;
    logic [ADDR_W-1:0] rt;
    logic              uses_rs;
    logic              uses_rt;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              is_load;
    logic              long_op;
    logic [CTRL_W-1:0] ctrl_in;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] rf_rs_data;
    logic [DATA_W-1:0] rf_rt_data;
    logic              fwd_mem_valid;
    logic [ADDR_W-1:0] fwd_mem_rd;
    logic [DATA_W-1:0] fwd_mem_data;
    logic              fwd_wb_valid;
    logic [ADDR_W-1:0] fwd_wb_rd;
    logic [DATA_W-1:0] fwd_wb_data;
    logic              stall;
    logic              long_busy;
    logic              ex_valid;
    logic              ex_reg_write;
    logic              ex_is_load;
    logic [ADDR_W-1:0] ex_rs;
    logic [ADDR_W-1:0] ex_rt;
    logic [ADDR_W-1:0] ex_rd;
    logic [DATA_W-1:0] ex_rs_data;
    logic [DATA_W-1:0] ex_rt_data;
    logic [DATA_W-1:0] ex_pc_plus4;
    logic [DATA_W-1:0] ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;

    id_issue_stage #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CTRL_W(CTRL_W), .LONG_LAT(LONG_LAT)
    ) dut (
        .clk(clk), .reset(reset), .hold(hold), .flush(flush), .valid_in(valid_in),
        .rs(rs), .rt(rt), .uses_rs(uses_rs), .uses_rt(uses_rt), .rd(rd),
        .reg_write(reg_write), .is_load(is_load), .long_op(long_op), .ctrl_in(ctrl_in),
        .pc_plus4(pc_plus4), .imm(imm), .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .fwd_mem_valid(fwd_mem_valid), .fwd_mem_rd(fwd_mem_rd), .fwd_mem_data(fwd_mem_data),
        .fwd_wb_valid(fwd_wb_valid), .fwd_wb_rd(fwd_wb_rd), .fwd_wb_data(fwd_wb_data),
        .stall(stall), .long_busy(long_busy), .ex_valid(ex_valid),
        .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_pc_plus4(ex_pc_plus4), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl)
    );

    typedef struct {
        logic [ADDR_W-1:0] rs, rt, rd;
        logic [DATA_W-1:0] rs_data, rt_data, pc, imm;
        logic [CTRL_W-1:0] ctrl;
        logic              is_load, reg_write;
    } exp_t;

    exp_t              sb[$];
    exp_t              last;
    int                checks = 0;
    int                errors = 0;
    logic [DATA_W-1:0] exp_rs;
    logic [DATA_W-1:0] exp_rt;
    bit                last_valid = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_instr(input logic [ADDR_W-1:0] rs_i, input logic [ADDR_W-1:0] rt_i,
                             input logic [ADDR_W-1:0] rd_i, input bit urs, input bit urt,
                             input bit rw, input bit ld, input bit lo);
        valid_in      = 1'b1;
        flush         = 1'b0;
        rs            = rs_i;
        rt            = rt_i;
        rd            = rd_i;
        uses_rs       = urs;
        uses_rt       = urt;
        reg_write     = rw;
        is_load       = ld;
        long_op       = lo;
        ctrl_in       = CTRL_W'($urandom);
        pc_plus4      = $urandom;
        imm           = $urandom;
        rf_rs_data    = $urandom;
        rf_rt_data    = $urandom;
        fwd_mem_valid = 1'b0;
        fwd_mem_rd    = '0;
        fwd_mem_data  = $urandom;
        fwd_wb_valid  = 1'b0;
        fwd_wb_rd     = '0;
        fwd_wb_data   = $urandom;
        exp_rs        = (rs_i == '0) ? '0 : rf_rs_data;
        exp_rt        = (rt_i == '0) ? '0 : rf_rt_data;
    endtask

    // Called just after a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step(input bit exp_stall, input bit exp_issue, input bit exp_busy);
        exp_t e;
        bit   exp_v;
        #1;
        check("stall", stall, exp_stall);
        if (exp_issue) begin
            e.rs = rs; e.rt = rt; e.rd = rd;
            e.rs_data = exp_rs; e.rt_data = exp_rt;
            e.pc = pc_plus4; e.imm = imm; e.ctrl = ctrl_in;
            e.is_load = is_load; e.reg_write = reg_write;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        exp_v = hold ? last_valid : exp_issue;
        check("ex_valid", ex_valid, exp_v);
        check("long_busy", long_busy, exp_busy);
        if (hold) begin
            if (last_valid) begin
                check("hold_ex_rd", ex_rd, last.rd);
                check("hold_ex_rs_data", ex_rs_data, last.rs_data);
            end
        end else if (ex_valid) begin
            check("sb_depth", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ex_rs", ex_rs, e.rs);
                check("ex_rt", ex_rt, e.rt);
                check("ex_rd", ex_rd, e.rd);
                check("ex_rs_data", ex_rs_data, e.rs_data);
                check("ex_rt_data", ex_rt_data, e.rt_data);
                check("ex_pc_plus4", ex_pc_plus4, e.pc);
                check("ex_imm", ex_imm, e.imm);
                check("ex_ctrl", ex_ctrl, e.ctrl);
                check("ex_is_load", ex_is_load, e.is_load);
                check("ex_reg_write", ex_reg_write, e.reg_write);
                last = e;
            end
        end
        last_valid = exp_v;
    endtask

    initial begin
        reset = 1'b1; hold = 1'b0;
        set_instr(0, 0, 0, 0, 0, 0, 0, 0);
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ex_valid", ex_valid, 0);
        check("rst_long_busy", long_busy, 0);
        check("rst_ex_rd", ex_rd, 0);
        check("rst_ex_rs_data", ex_rs_data, 0);
        check("rst_stall", stall, 0);
        reset = 1'b0;

        // load r5 then dependent add: one stall, one bubble, then issue
        set_instr(1, 2, 5, 1, 1, 1, 1, 0);  step(0, 1, 0);
        set_instr(5, 0, 6, 1, 0, 1, 0, 0);  step(1, 0, 0);
        step(0, 1, 0);

        // load r5 then rt=5 without uses_rt: no stall
        set_instr(1, 2, 5, 1, 1, 1, 1, 0);  step(0, 1, 0);
        set_instr(1, 5, 8, 1, 0, 1, 0, 0);  step(0, 1, 0);

        // mul r7 then consumer: four stall cycles, issue on the fifth
        set_instr(1, 2, 7, 1, 1, 1, 0, 1);  step(0, 1, 1);
        set_instr(7, 2, 8, 1, 1, 1, 0, 0);
        for (int i = 0; i < LONG_LAT - 1; i++) step(1, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);

        // second mul while the counter runs: structural stall
        set_instr(1, 2, 7, 1, 1, 1, 0, 1);  step(0, 1, 1);
        set_instr(1, 2, 9, 1, 1, 1, 0, 1);
        for (int i = 0; i < LONG_LAT - 1; i++) step(1, 0, 1);
        step(1, 0, 0);
        step(0, 1, 1);

        // bring count to 2, then hold 3 cycles with a consumer of r9 in ID
        set_instr(1, 2, 10, 1, 1, 1, 0, 0); step(0, 1, 1);
        set_instr(1, 2, 12, 1, 1, 1, 0, 0); step(0, 1, 1);
        set_instr(9, 2, 13, 1, 1, 1, 0, 0);
        hold = 1'b1;
        for (int i = 0; i < 3; i++) step(1, 0, 1);
        hold = 1'b0;
        step(1, 0, 1);
        step(1, 0, 0);
        step(0, 1, 0);

        // flush coinciding with a load-use hazard
        set_instr(1, 2, 5, 1, 1, 1, 1, 0);  step(0, 1, 0);
        set_instr(5, 2, 6, 1, 1, 1, 0, 0);
        flush = 1'b1;
        step(0, 0, 0);
        flush = 1'b0; valid_in = 1'b0;
        step(0, 0, 0);

        // forwarding priority: EX/MEM over WB over register file
        set_instr(3, 4, 11, 1, 1, 1, 0, 0);
        fwd_mem_valid = 1'b1; fwd_mem_rd = 3; fwd_mem_data = 32'hDEADBEEF;
        fwd_wb_valid  = 1'b1; fwd_wb_rd  = 3; fwd_wb_data  = 32'h12345678;
        exp_rs = 32'hDEADBEEF;
        step(0, 1, 0);
        fwd_mem_valid = 1'b0;
`ifdef ID_WB_BYPASS_EN
        exp_rs = 32'h12345678;
`else
        exp_rs = rf_rs_data;
`endif
        step(0, 1, 0);
        set_instr(0, 3, 14, 1, 1, 1, 0, 0);
        fwd_mem_valid = 1'b1; fwd_mem_rd = 0; fwd_mem_data = 32'hDEADBEEF;
        fwd_wb_valid  = 1'b1; fwd_wb_rd  = 3; fwd_wb_data  = 32'h12345678;
        exp_rs = '0;
`ifdef ID_WB_BYPASS_EN
        exp_rt = 32'h12345678;
`endif
        step(0, 1, 0);

        // reset in the middle of a long count
        set_instr(1, 2, 7, 1, 1, 1, 0, 1);  step(0, 1, 1);
        valid_in = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_long_busy", long_busy, 0);
        check("midrst_ex_valid", ex_valid, 0);
        @(negedge clk);
        reset = 1'b0;
        last_valid = 1'b0;
        set_instr(7, 2, 8, 1, 1, 1, 0, 0);  step(0, 1, 0);

        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
